inst_length_aligner: RTL and testbench

- Generalised successor to the single-byte two-byte-instruction classifier.
- Accepts a stream of code bytes from the fetch unit, FETCH_BYTES per beat, into a small circular byte buffer.
- Classifies every MCS-51 opcode as 1, 2 or 3 bytes long and flags relative branches.
- Presents one complete, aligned instruction (opcode plus operands, with its PC) per cycle to the decoder over a valid/ready handshake; supports flush/redirect on taken branches.

---
 rtl/inst_length_aligner.sv | 155 +++++++++++++++
 tb/tb_inst_length_aligner.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_length_aligner.sv
// MCS-51 instruction length aligner: collects fetched code bytes in a small
// circular buffer and issues one aligned, length-classified instruction per cycle.
module inst_length_aligner #(
  parameter int FETCH_BYTES = 2,
  parameter int BUF_DEPTH   = 8,
  parameter int PC_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [8*FETCH_BYTES-1:0] fetch_data,
  input  logic                     flush,
  input  logic [PC_WIDTH-1:0]      flush_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [7:0]               inst_opcode,
  output logic [7:0]               inst_op1,
  output logic [7:0]               inst_op2,
  output logic [1:0]               inst_len,
  output logic [PC_WIDTH-1:0]      inst_pc,
  output logic                     inst_is_rel_branch
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] BEAT_C  = CNT_W'(FETCH_BYTES);

  // AJMP/ACALL occupy every opcode whose low nibble is 1, so they are tested first.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic [1:0] len;
    if (op[3:0] == 4'h1) begin
      len = 2'd2;
    end else begin
      case (op) inside
        8'h02, 8'h12, 8'h10, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63,
        8'h75, 8'h85, 8'h90, [8'hB4:8'hBF], 8'hD5:
          len = 2'd3;
        8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40, 8'h42,
        8'h44, 8'h45, 8'h50, 8'h52, 8'h54, 8'h55, 8'h60, 8'h62,
        8'h64, 8'h65, 8'h70, 8'h72, 8'h74, 8'h76, 8'h77, [8'h78:8'h7F],
        8'h80, 8'h82, [8'h86:8'h8F], 8'h92, 8'h94, 8'h95, 8'hA0, 8'hA2,
        [8'hA6:8'hAF], 8'hB0, 8'hB2, 8'hC0, 8'hC2, 8'hC5, 8'hD0, 8'hD2,
        [8'hD8:8'hDF], 8'hE5, 8'hF5:
          len = 2'd2;
        default:
          len = 2'd1;
      endcase
    end
    return len;
  endfunction

  function automatic logic op_is_rel(input logic [7:0] op);
    logic rel;
    case (op) inside
      8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80,
      [8'hB4:8'hBF], 8'hD5, [8'hD8:8'hDF]:
        rel = 1'b1;
      default:
        rel = 1'b0;
    endcase
    return rel;
  endfunction

  logic [7:0]          buf_q [BUF_DEPTH];
  logic [7:0]          buf_d [BUF_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;

  logic [7:0]       head_s, byte1_s, byte2_s;
  logic [1:0]       len_s;
  logic [CNT_W-1:0] len_cnt_s;
  logic             push_s, pop_s;

  assign head_s    = buf_q[rd_ptr_q];
  assign byte1_s   = buf_q[rd_ptr_q + PTR_W'(32'd1)];
  assign byte2_s   = buf_q[rd_ptr_q + PTR_W'(32'd2)];
  assign len_s     = op_len(head_s);
  assign len_cnt_s = {{(CNT_W-2){1'b0}}, len_s};

  // Handshakes and instruction fields; fetch_ready looks only at the registered count.
  always_comb begin
    fetch_ready        = (DEPTH_C - count_q) >= BEAT_C;
    inst_valid         = (count_q >= len_cnt_s) && !flush;
    push_s             = fetch_valid && fetch_ready && !flush;
    pop_s              = inst_valid && inst_ready;
    inst_opcode        = head_s;
    inst_op1           = (len_s >= 2'd2) ? byte1_s : 8'h00;
    inst_op2           = (len_s == 2'd3) ? byte2_s : 8'h00;
    inst_len           = len_s;
    inst_pc            = pc_q;
    inst_is_rel_branch = op_is_rel(head_s);
  end

  // Pointer, count and PC next state; flush overrides any push or pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = flush_pc;
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(len_s);
        pc_d     = pc_q + PC_WIDTH'(len_s);
      end else begin
        rd_ptr_d = rd_ptr_q;
        pc_d     = pc_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(FETCH_BYTES);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      count_d = count_q + (push_s ? BEAT_C : '0) - (pop_s ? len_cnt_s : '0);
    end
  end

  // Byte buffer write: a beat lands at wr_ptr and wraps around the ring.
  always_comb begin
    buf_d = buf_q;
    if (push_s) begin
      for (int i = 0; i < FETCH_BYTES; i++) begin
        buf_d[wr_ptr_q + PTR_W'(i)] = fetch_data[8*i +: 8];
      end
    end else begin
      buf_d = buf_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q    <= '{default: 8'h00};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= '0;
    end else begin
      buf_q    <= buf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
    end
  end

endmodule

// File: tb/tb_inst_length_aligner.sv
// Self-checking bench for inst_length_aligner (FETCH_BYTES=2, BUF_DEPTH=8):
// scoreboard of expected instructions plus directed corner-case sequences.
module tb_inst_length_aligner;

  typedef struct packed {
    logic [7:0]  opc;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [1:0]  len;
    logic [15:0] pc;
    logic        rel;
  } inst_t;

  typedef struct {
    logic [7:0] op;
    logic [1:0] len;
    logic       rel;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [15:0] fetch_data;
  logic        flush;
  logic [15:0] flush_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [7:0]  inst_opcode;
  logic [7:0]  inst_op1;
  logic [7:0]  inst_op2;
  logic [1:0]  inst_len;
  logic [15:0] inst_pc;
  logic        inst_is_rel_branch;

  int          checks;
  int          failures;
  inst_t       exp_q[$];
  inst_t       mon_act;
  inst_t       mon_exp;
  logic [15:0] cur_pc;
  logic [1:0]  len_tab [256];
  logic        rel_tab [256];
  vec_t        vecs [18];
  logic [7:0]  bp [14];

  inst_length_aligner #(.FETCH_BYTES(2), .BUF_DEPTH(8), .PC_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .flush(flush), .flush_pc(flush_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_opcode(inst_opcode), .inst_op1(inst_op1), .inst_op2(inst_op2),
    .inst_len(inst_len), .inst_pc(inst_pc), .inst_is_rel_branch(inst_is_rel_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: an issued instruction is compared one half-cycle before its pop edge.
  always @(negedge clk) begin
    if (reset_n && inst_valid && inst_ready) begin
      mon_act = {inst_opcode, inst_op1, inst_op2, inst_len, inst_pc, inst_is_rel_branch};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL inst_unexpected: got opc=%h len=%0d pc=%h, required no instruction",
                 inst_opcode, inst_len, inst_pc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL inst_out: got opc=%h op1=%h op2=%h len=%0d pc=%h rel=%b, required opc=%h op1=%h op2=%h len=%0d pc=%h rel=%b",
                   mon_act.opc, mon_act.op1, mon_act.op2, mon_act.len, mon_act.pc, mon_act.rel,
                   mon_exp.opc, mon_exp.op1, mon_exp.op2, mon_exp.len, mon_exp.pc, mon_exp.rel);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_valid"}, 32'(inst_valid), 32'h0);
    check({name, "_opcode"}, 32'(inst_opcode), 32'h0);
    check({name, "_op1"}, 32'(inst_op1), 32'h0);
    check({name, "_op2"}, 32'(inst_op2), 32'h0);
    check({name, "_len"}, 32'(inst_len), 32'h1);
    check({name, "_pc"}, 32'(inst_pc), 32'h0);
    check({name, "_rel"}, 32'(inst_is_rel_branch), 32'h0);
    check({name, "_fetch_ready"}, 32'(fetch_ready), 32'h1);
  endtask

  task automatic expect_inst(input logic [7:0] opc, input logic [7:0] op1, input logic [7:0] op2,
                             input logic [1:0] len, input logic [15:0] pc, input logic rel);
    inst_t e;
    e = {opc, op1, op2, len, pc, rel};
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    fetch_valid = 1'b0;
    flush       = 1'b0;
    inst_ready  = 1'b0;
    fetch_data  = 16'h0000;
    flush_pc    = 16'h0000;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("reset");
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Hold the beat until the DUT can take it; returns 1 time unit after the accepting edge.
  task automatic send_beat(input logic [7:0] b0, input logic [7:0] b1);
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    fetch_valid = 1'b1;
    fetch_data  = {b1, b0};
    while (!ok && n < 200) begin
      @(negedge clk);
      if (fetch_ready) ok = 1'b1;
      else n++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: fetch_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d instructions still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic feed_op(input logic [7:0] op, input logic [1:0] len, input logic rel);
    expect_inst(op, 8'h00, 8'h00, len, cur_pc, rel);
    for (int k = int'(len); k < 4; k++) begin
      expect_inst(8'h00, 8'h00, 8'h00, 2'd1, cur_pc + 16'(k), 1'b0);
    end
    cur_pc = cur_pc + 16'd4;
    send_beat(op, 8'h00);
    send_beat(8'h00, 8'h00);
  endtask

  // Reference opcode tables, built straight from the opcode lists.
  task automatic build_tables();
    logic [7:0] two_l[$];
    logic [7:0] three_l[$];
    logic [7:0] rel_l[$];
    two_l = '{8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40, 8'h42, 8'h44, 8'h45,
              8'h50, 8'h52, 8'h54, 8'h55, 8'h60, 8'h62, 8'h64, 8'h65, 8'h70, 8'h72,
              8'h74, 8'h76, 8'h77, 8'h80, 8'h82, 8'h92, 8'h94, 8'h95, 8'hA0, 8'hA2,
              8'hB0, 8'hB2, 8'hC0, 8'hC2, 8'hC5, 8'hD0, 8'hD2, 8'hE5, 8'hF5};
    three_l = '{8'h02, 8'h12, 8'h10, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63, 8'h75,
                8'h85, 8'h90, 8'hD5};
    rel_l = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'hD5};
    for (int i = 0; i < 256; i++) begin
      len_tab[i] = 2'd1;
      rel_tab[i] = 1'b0;
    end
    for (int hi = 0; hi < 8; hi++) begin
      len_tab[hi*32 + 1]  = 2'd2;
      len_tab[hi*32 + 17] = 2'd2;
    end
    foreach (two_l[k]) len_tab[two_l[k]] = 2'd2;
    for (int i = 32'h78; i <= 32'h7F; i++) len_tab[i] = 2'd2;
    for (int i = 32'h86; i <= 32'h8F; i++) len_tab[i] = 2'd2;
    for (int i = 32'hA6; i <= 32'hAF; i++) len_tab[i] = 2'd2;
    for (int i = 32'hD8; i <= 32'hDF; i++) len_tab[i] = 2'd2;
    foreach (three_l[k]) len_tab[three_l[k]] = 2'd3;
    for (int i = 32'hB4; i <= 32'hBF; i++) len_tab[i] = 2'd3;
    foreach (rel_l[k]) rel_tab[rel_l[k]] = 1'b1;
    for (int i = 32'hB4; i <= 32'hBF; i++) rel_tab[i] = 1'b1;
    for (int i = 32'hD8; i <= 32'hDF; i++) rel_tab[i] = 1'b1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    fetch_valid = 1'b0;
    fetch_data  = 16'h0000;
    flush       = 1'b0;
    flush_pc    = 16'h0000;
    inst_ready  = 1'b0;
    cur_pc      = 16'h0000;
    build_tables();

    vecs[0]  = '{8'h00, 2'd1, 1'b0};  vecs[1]  = '{8'hA5, 2'd1, 1'b0};
    vecs[2]  = '{8'h02, 2'd3, 1'b0};  vecs[3]  = '{8'h75, 2'd3, 1'b0};
    vecs[4]  = '{8'h80, 2'd2, 1'b1};  vecs[5]  = '{8'hB4, 2'd3, 1'b1};
    vecs[6]  = '{8'hBF, 2'd3, 1'b1};  vecs[7]  = '{8'hD5, 2'd3, 1'b1};
    vecs[8]  = '{8'hD8, 2'd2, 1'b1};  vecs[9]  = '{8'hDF, 2'd2, 1'b1};
    vecs[10] = '{8'h11, 2'd2, 1'b0};  vecs[11] = '{8'hF1, 2'd2, 1'b0};
    vecs[12] = '{8'h40, 2'd2, 1'b1};  vecs[13] = '{8'h10, 2'd3, 1'b1};
    vecs[14] = '{8'hE4, 2'd1, 1'b0};  vecs[15] = '{8'h90, 2'd3, 1'b0};
    vecs[16] = '{8'h78, 2'd2, 1'b0};  vecs[17] = '{8'h05, 2'd2, 1'b0};

    bp = '{8'h04, 8'h75, 8'hA5, 8'h5A, 8'hE5, 8'h33, 8'h80, 8'hFE,
           8'h23, 8'hB4, 8'h11, 8'h22, 8'h11, 8'h77};

    // Basic stream and first-instruction latency.
    do_reset();
    inst_ready = 1'b1;
    expect_inst(8'h02, 8'h12, 8'h34, 2'd3, 16'h0000, 1'b0);
    expect_inst(8'hE5, 8'h80, 8'h00, 2'd2, 16'h0003, 1'b0);
    expect_inst(8'h00, 8'h00, 8'h00, 2'd1, 16'h0005, 1'b0);
    send_beat(8'h02, 8'h12);
    check("lat_after_beat1", 32'(inst_valid), 32'h0);
    send_beat(8'h34, 8'hE5);
    check("lat_after_beat2", 32'(inst_valid), 32'h1);
    send_beat(8'h80, 8'h00);
    fetch_valid = 1'b0;
    drain("stream");

    // Hand-entered classification vectors.
    do_reset();
    inst_ready = 1'b1;
    cur_pc = 16'h0000;
    for (int v = 0; v < 18; v++) begin
      feed_op(vecs[v].op, vecs[v].len, vecs[v].rel);
    end
    fetch_valid = 1'b0;
    drain("vectors");

    // Full opcode sweep.
    do_reset();
    inst_ready = 1'b1;
    cur_pc = 16'h0000;
    for (int op = 0; op < 256; op++) begin
      feed_op(8'(op), len_tab[op], rel_tab[op]);
    end
    fetch_valid = 1'b0;
    drain("sweep");

    // Back-pressure: fill to 8 bytes, hold the next beat, then release across the wrap.
    do_reset();
    expect_inst(8'h04, 8'h00, 8'h00, 2'd1, 16'h0000, 1'b0);
    expect_inst(8'h75, 8'hA5, 8'h5A, 2'd3, 16'h0001, 1'b0);
    expect_inst(8'hE5, 8'h33, 8'h00, 2'd2, 16'h0004, 1'b0);
    expect_inst(8'h80, 8'hFE, 8'h00, 2'd2, 16'h0006, 1'b1);
    expect_inst(8'h23, 8'h00, 8'h00, 2'd1, 16'h0008, 1'b0);
    expect_inst(8'hB4, 8'h11, 8'h22, 2'd3, 16'h0009, 1'b1);
    expect_inst(8'h11, 8'h77, 8'h00, 2'd2, 16'h000C, 1'b0);
    for (int b = 0; b < 4; b++) send_beat(bp[2*b], bp[2*b+1]);
    fetch_valid = 1'b1;
    fetch_data  = {bp[9], bp[8]};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_full_ready", 32'(fetch_ready), 32'h0);
      check("bp_full_valid", 32'(inst_valid), 32'h1);
      check("bp_head_masked_op1", 32'(inst_op1), 32'h0);
      @(posedge clk); #1;
    end
    inst_ready = 1'b1;
    for (int b = 4; b < 7; b++) send_beat(bp[2*b], bp[2*b+1]);
    fetch_valid = 1'b0;
    drain("backpressure");

    // Split instruction: 75 waits for its operand bytes.
    do_reset();
    inst_ready = 1'b1;
    expect_inst(8'h00, 8'h00, 8'h00, 2'd1, 16'h0000, 1'b0);
    expect_inst(8'h75, 8'h30, 8'h40, 2'd3, 16'h0001, 1'b0);
    send_beat(8'h00, 8'h75);
    fetch_valid = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("split_wait_valid", 32'(inst_valid), 32'h0);
      check("split_wait_head", 32'(inst_opcode), 32'h75);
      @(posedge clk); #1;
    end
    send_beat(8'h30, 8'h40);
    fetch_valid = 1'b0;
    drain("split");

    // Flush with five bytes buffered while both handshakes are active.
    do_reset();
    expect_inst(8'h04, 8'h00, 8'h00, 2'd1, 16'h0000, 1'b0);
    send_beat(8'h04, 8'h05);
    send_beat(8'h06, 8'h07);
    send_beat(8'h08, 8'h09);
    fetch_valid = 1'b0;
    inst_ready  = 1'b1;
    @(posedge clk); #1;
    flush       = 1'b1;
    flush_pc    = 16'h1234;
    fetch_valid = 1'b1;
    fetch_data  = 16'hA5A5;
    @(negedge clk);
    check("flush_cycle_valid", 32'(inst_valid), 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_after_valid", 32'(inst_valid), 32'h0);
    check("flush_after_ready", 32'(fetch_ready), 32'h1);
    expect_inst(8'hA5, 8'h00, 8'h00, 2'd1, 16'h1234, 1'b0);
    expect_inst(8'hA5, 8'h00, 8'h00, 2'd1, 16'h1235, 1'b0);
    send_beat(8'hA5, 8'hA5);
    fetch_valid = 1'b0;
    drain("flush");

    // Asynchronous reset with six bytes buffered, then PC wrap after a flush.
    do_reset();
    send_beat(8'h75, 8'h30);
    send_beat(8'h40, 8'hE5);
    send_beat(8'h80, 8'h12);
    fetch_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_valid", 32'(inst_valid), 32'h1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("rst_async");
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b1;
    expect_inst(8'h04, 8'h00, 8'h00, 2'd1, 16'h0000, 1'b0);
    expect_inst(8'h00, 8'h00, 8'h00, 2'd1, 16'h0001, 1'b0);
    send_beat(8'h04, 8'h00);
    fetch_valid = 1'b0;
    drain("post_reset");
    flush    = 1'b1;
    flush_pc = 16'hFFFF;
    @(posedge clk); #1;
    flush = 1'b0;
    expect_inst(8'h02, 8'hAB, 8'hCD, 2'd3, 16'hFFFF, 1'b0);
    expect_inst(8'h04, 8'h00, 8'h00, 2'd1, 16'h0002, 1'b0);
    send_beat(8'h02, 8'hAB);
    send_beat(8'hCD, 8'h04);
    fetch_valid = 1'b0;
    drain("pc_wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
